// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module : mc_pkg
// Brief  : State encodings, opcode/funct codes and mux/ALU select codes
//          shared by the multi-cycle control unit.
// Rev    : 1.0  initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    localparam logic [5:0] C_FN_ADD = 6'b100000;
    localparam logic [5:0] C_FN_SUB = 6'b100010;
    localparam logic [5:0] C_FN_AND = 6'b100100;
    localparam logic [5:0] C_FN_OR  = 6'b100101;
    localparam logic [5:0] C_FN_SLT = 6'b101010;

    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

    localparam logic       C_SRCA_PC  = 1'b0;
    localparam logic       C_SRCA_REG = 1'b1;

    localparam logic [1:0] C_SRCB_REG   = 2'b00;
    localparam logic [1:0] C_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] C_SRCB_IMM   = 2'b10;
    localparam logic [1:0] C_SRCB_IMMSH = 2'b11;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == C_OP_LW) || (op == C_OP_SW);
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            C_OP_RTYPE, C_OP_LW, C_OP_SW,
            C_OP_BEQ, C_OP_ADDI, C_OP_J: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module : mc_alu_decoder
// Brief  : Combinational R-type funct to ALU control decode with illegal flag.
// Rev    : 1.0  initial release
// ============================================================================
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctrl = C_ALU_ADD;
        o_illegal  = 1'b0;
        case (i_funct)
            C_FN_ADD: o_alu_ctrl = C_ALU_ADD;
            C_FN_SUB: o_alu_ctrl = C_ALU_SUB;
            C_FN_AND: o_alu_ctrl = C_ALU_AND;
            C_FN_OR:  o_alu_ctrl = C_ALU_OR;
            C_FN_SLT: o_alu_ctrl = C_ALU_SLT;
            default:  o_illegal  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module : mc_control_fsm
// Brief  : Multi-cycle MIPS-subset control unit with memory ready handshake
//          and retired-instruction counter.
// Rev    : 1.0  initial release
// ============================================================================
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int ILLEGAL_HLT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [2:0]       w_funct_alu;
    logic             w_funct_ill;
    logic             w_illegal;
    logic             w_retire;

    mc_alu_decoder u_alu_dec (
        .i_funct    (funct),
        .o_alu_ctrl (w_funct_alu),
        .o_illegal  (w_funct_ill)
    );

    assign w_illegal = !is_known_op(op) || ((op == C_OP_RTYPE) && w_funct_ill);

    // A store retires on its completing handshake; every other legal
    // instruction retires on leaving its last state.
    assign w_retire = (state_q == ST_MEMWB)  || (state_q == ST_ALUWB)  ||
                      (state_q == ST_BRANCH) || (state_q == ST_ADDIWB) ||
                      (state_q == ST_JUMP)   || ((state_q == ST_MEMWR) && mem_ready);

    assign instret_d = instret_q + CNT_W'(w_retire);
    assign instret   = instret_q;
    assign halted    = (state_q == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = C_PCSRC_ALU;
        alu_src_a  = C_SRCA_PC;
        alu_src_b  = C_SRCB_REG;
        alu_ctrl   = 3'b000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = C_SRCB_FOUR;
                alu_ctrl  = C_ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b = C_SRCB_IMMSH;
                alu_ctrl  = C_ALU_ADD;
                if (w_illegal) begin
                    illegal_op = 1'b1;
                    state_d    = (ILLEGAL_HLT != 0) ? ST_HALT : ST_FETCH;
                end else if (is_mem_op(op)) begin
                    state_d = ST_MEMADR;
                end else if (op == C_OP_RTYPE) begin
                    state_d = ST_EXEC;
                end else if (op == C_OP_BEQ) begin
                    state_d = ST_BRANCH;
                end else if (op == C_OP_ADDI) begin
                    state_d = ST_ADDIEX;
                end else begin
                    state_d = ST_JUMP;
                end
            end
            ST_MEMADR: begin
                alu_src_a = C_SRCA_REG;
                alu_src_b = C_SRCB_IMM;
                alu_ctrl  = C_ALU_ADD;
                state_d   = (op == C_OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXEC: begin
                alu_src_a = C_SRCA_REG;
                alu_ctrl  = w_funct_alu;
                state_d   = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = C_SRCA_REG;
                alu_ctrl  = C_ALU_SUB;
                pc_src    = C_PCSRC_ALUOUT;
                pc_en     = zero;
                state_d   = ST_FETCH;
            end
            ST_ADDIEX: begin
                alu_src_a = C_SRCA_REG;
                alu_src_b = C_SRCB_IMM;
                alu_ctrl  = C_ALU_ADD;
                state_d   = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src  = C_PCSRC_JUMP;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_mc_control_fsm
// Brief  : Scoreboard bench: stimulus queues per-cycle expected outputs,
//          a negedge monitor pops and compares them.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

    // Vector layout: req wr iord irw pcen pcsrc[2] sa sb[2] alu[3] rw rd m2r ill hlt
    localparam logic [17:0] M_STB  = 18'b1_1_0_1_1_00_0_00_000_1_0_0_1_1;
    localparam logic [17:0] M_IORD = 18'b0_0_1_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] M_PCS  = 18'b0_0_0_0_0_11_0_00_000_0_0_0_0_0;
    localparam logic [17:0] M_ALU  = 18'b0_0_0_0_0_00_1_11_111_0_0_0_0_0;
    localparam logic [17:0] M_WB   = 18'b0_0_0_0_0_00_0_00_000_0_1_1_0_0;
    localparam logic [17:0] M_ALL  = 18'h3FFFF;

    localparam logic [17:0] V_IDLE  = 18'b0_0_0_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] V_FWAIT = 18'b1_0_0_0_0_00_0_01_010_0_0_0_0_0;
    localparam logic [17:0] V_FGO   = 18'b1_0_0_1_1_00_0_01_010_0_0_0_0_0;
    localparam logic [17:0] V_DEC   = 18'b0_0_0_0_0_00_0_11_010_0_0_0_0_0;
    localparam logic [17:0] V_DECI  = 18'b0_0_0_0_0_00_0_11_010_0_0_0_1_0;
    localparam logic [17:0] V_MADR  = 18'b0_0_0_0_0_00_1_10_010_0_0_0_0_0;
    localparam logic [17:0] V_MRD   = 18'b1_0_1_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] V_MWB   = 18'b0_0_0_0_0_00_0_00_000_1_0_1_0_0;
    localparam logic [17:0] V_MWR   = 18'b1_1_1_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] V_AWB   = 18'b0_0_0_0_0_00_0_00_000_1_1_0_0_0;
    localparam logic [17:0] V_BRT   = 18'b0_0_0_0_1_01_1_00_110_0_0_0_0_0;
    localparam logic [17:0] V_BRF   = 18'b0_0_0_0_0_01_1_00_110_0_0_0_0_0;
    localparam logic [17:0] V_IWB   = 18'b0_0_0_0_0_00_0_00_000_1_0_0_0_0;
    localparam logic [17:0] V_JMP   = 18'b0_0_0_0_1_10_0_00_000_0_0_0_0_0;
    localparam logic [17:0] V_HALT  = 18'b0_0_0_0_0_00_0_00_000_0_0_0_0_1;

    typedef struct {
        logic [17:0] v;
        logic [17:0] m;
        logic [31:0] cnt;
        bit          use_b;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, rst_n_b;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;

    logic a_req, a_wr, a_iord, a_irw, a_pcen, a_sa, a_rw, a_rd, a_m2r, a_ill, a_hlt;
    logic [1:0]  a_pcs, a_sb;
    logic [2:0]  a_alu;
    logic [31:0] a_instret;
    logic b_req, b_wr, b_iord, b_irw, b_pcen, b_sa, b_rw, b_rd, b_m2r, b_ill, b_hlt;
    logic [1:0]  b_pcs, b_sb;
    logic [2:0]  b_alu;
    logic [3:0]  b_instret;

    logic [17:0] vec_a, vec_b;
    assign vec_a = {a_req, a_wr, a_iord, a_irw, a_pcen, a_pcs, a_sa, a_sb, a_alu, a_rw, a_rd, a_m2r, a_ill, a_hlt};
    assign vec_b = {b_req, b_wr, b_iord, b_irw, b_pcen, b_pcs, b_sa, b_sb, b_alu, b_rw, b_rd, b_m2r, b_ill, b_hlt};

    mc_control_fsm #(.CNT_W(32), .ILLEGAL_HLT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_req), .mem_write(a_wr), .iord(a_iord), .ir_write(a_irw), .pc_en(a_pcen),
        .pc_src(a_pcs), .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_ctrl(a_alu), .reg_write(a_rw),
        .reg_dst(a_rd), .mem_to_reg(a_m2r), .illegal_op(a_ill), .halted(a_hlt), .instret(a_instret)
    );

    mc_control_fsm #(.CNT_W(4), .ILLEGAL_HLT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_req), .mem_write(b_wr), .iord(b_iord), .ir_write(b_irw), .pc_en(b_pcen),
        .pc_src(b_pcs), .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_ctrl(b_alu), .reg_write(b_rw),
        .reg_dst(b_rd), .mem_to_reg(b_m2r), .illegal_op(b_ill), .halted(b_hlt), .instret(b_instret)
    );

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          use_b  = 1'b0;
    logic [31:0] exp_cnt;
    logic [17:0] act_v;
    logic [31:0] act_c, req_c;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL scoreboard_underflow: actual=empty required=entry");
            end else begin
                mon_e = sb_q.pop_front();
                act_v = mon_e.use_b ? vec_b : vec_a;
                act_c = mon_e.use_b ? {28'd0, b_instret} : a_instret;
                req_c = mon_e.use_b ? (mon_e.cnt & 32'hF) : mon_e.cnt;
                n_chk++;
                if ((act_v & mon_e.m) !== (mon_e.v & mon_e.m)) begin
                    n_err++;
                    $display("FAIL %s ctrl: actual=%b required=%b mask=%b @%0t",
                             mon_e.nm, act_v & mon_e.m, mon_e.v & mon_e.m, mon_e.m, $time);
                end
                n_chk++;
                if (act_c !== req_c) begin
                    n_err++;
                    $display("FAIL %s instret: actual=%0d required=%0d @%0t",
                             mon_e.nm, act_c, req_c, $time);
                end
            end
        end
    end

    task automatic cyc(input logic [17:0] v, input logic [17:0] m, input string nm);
        exp_t e;
        e.v = v; e.m = m; e.cnt = exp_cnt; e.use_b = use_b; e.nm = nm;
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [5:0] o, input logic [5:0] f, input int waits);
        op = o; funct = f;
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            cyc(V_FWAIT, M_STB | M_IORD | M_PCS | M_ALU, "fetch_wait");
        end
        mem_ready = 1'b1;
        cyc(V_FGO, M_STB | M_IORD | M_PCS | M_ALU, "fetch");
    endtask

    task automatic do_r(input logic [5:0] f, input logic [2:0] alu, input int fw);
        fetch(6'b000000, f, fw);
        cyc(V_DEC, M_STB | M_ALU, "r_decode");
        cyc({7'b0000000, 1'b1, 2'b00, alu, 5'b00000}, M_STB | M_ALU, "r_exec");
        cyc(V_AWB, M_STB | M_WB, "r_aluwb");
        exp_cnt++;
    endtask

    task automatic do_lw(input int mw);
        fetch(6'b100011, 6'd0, 0);
        cyc(V_DEC, M_STB | M_ALU, "lw_decode");
        cyc(V_MADR, M_STB | M_ALU, "lw_memadr");
        for (int i = 0; i < mw; i++) begin
            mem_ready = 1'b0;
            cyc(V_MRD, M_STB | M_IORD, "lw_memrd_wait");
        end
        mem_ready = 1'b1;
        cyc(V_MRD, M_STB | M_IORD, "lw_memrd");
        cyc(V_MWB, M_STB | M_WB, "lw_memwb");
        exp_cnt++;
    endtask

    task automatic do_sw(input int mw);
        fetch(6'b101011, 6'd0, 0);
        cyc(V_DEC, M_STB | M_ALU, "sw_decode");
        cyc(V_MADR, M_STB | M_ALU, "sw_memadr");
        for (int i = 0; i < mw; i++) begin
            mem_ready = 1'b0;
            cyc(V_MWR, M_STB | M_IORD, "sw_memwr_wait");
        end
        mem_ready = 1'b1;
        cyc(V_MWR, M_STB | M_IORD, "sw_memwr");
        exp_cnt++;
    endtask

    task automatic do_beq(input logic z);
        fetch(6'b000100, 6'd0, 0);
        cyc(V_DEC, M_STB | M_ALU, "beq_decode");
        zero = z;
        cyc(z ? V_BRT : V_BRF, M_STB | M_PCS | M_ALU, z ? "beq_taken" : "beq_not_taken");
        exp_cnt++;
        zero = 1'b0;
    endtask

    task automatic do_addi();
        fetch(6'b001000, 6'd0, 0);
        cyc(V_DEC, M_STB | M_ALU, "addi_decode");
        cyc(V_MADR, M_STB | M_ALU, "addi_ex");
        cyc(V_IWB, M_STB | M_WB, "addi_wb");
        exp_cnt++;
    endtask

    // mem_ready is held low through DECODE/JUMP, where it must be ignored.
    task automatic do_j();
        fetch(6'b000010, 6'd0, 0);
        mem_ready = 1'b0;
        cyc(V_DEC, M_STB | M_ALU, "j_decode");
        cyc(V_JMP, M_STB | M_PCS, "j_jump");
        exp_cnt++;
        mem_ready = 1'b1;
    endtask

    task automatic do_ill(input logic [5:0] o, input logic [5:0] f);
        fetch(o, f, 0);
        cyc(V_DECI, M_STB | M_ALU, "illegal_decode");
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        exp_cnt = 32'd0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        repeat (3) cyc(V_IDLE, M_ALL, "reset_low");
        rst_n_a = 1'b1;
        cyc(V_IDLE, M_ALL, "idle_after_reset");

        do_r(6'b100000, 3'b010, 0);
        do_r(6'b100010, 3'b110, 1);
        do_r(6'b100100, 3'b000, 0);
        do_r(6'b100101, 3'b001, 0);
        do_r(6'b101010, 3'b111, 2);
        do_lw(2);
        do_beq(1'b1);
        do_beq(1'b0);
        do_ill(6'b111111, 6'd0);
        do_ill(6'b000000, 6'b000000);
        do_addi();
        do_sw(1);
        do_j();

        // Reset asserted mid-store while the memory is still stalling.
        fetch(6'b101011, 6'd0, 0);
        cyc(V_DEC, M_STB | M_ALU, "sw2_decode");
        cyc(V_MADR, M_STB | M_ALU, "sw2_memadr");
        mem_ready = 1'b0;
        cyc(V_MWR, M_STB | M_IORD, "sw2_memwr_wait");
        rst_n_a = 1'b0;
        exp_cnt = 32'd0;
        cyc(V_IDLE, M_ALL, "reset_mid_memwr");
        rst_n_a = 1'b1;
        cyc(V_IDLE, M_ALL, "idle_restart");
        do_r(6'b100000, 3'b010, 0);

        // Narrow-counter instance that halts on an illegal opcode.
        use_b = 1'b1;
        exp_cnt = 32'd0;
        cyc(V_IDLE, M_ALL, "b_reset_low");
        rst_n_b = 1'b1;
        cyc(V_IDLE, M_ALL, "b_idle");
        repeat (17) do_j();
        do_ill(6'b111111, 6'd0);
        op = 6'b000010;
        repeat (3) cyc(V_HALT, M_ALL, "b_halted");

        mon_en = 1'b0;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
